// File: rtl/fifo_wr_ctrl_cdc_pkg.sv
// Shared helpers for the dual-clock FIFO pointer logic: Gray/binary conversion
// and common constants used by both the write and read controllers.
package fifo_wr_ctrl_cdc_pkg;

    localparam int PTR_W_MAX = 32;
    localparam logic [15:0] DROP_CNT_MAX = 16'hFFFF;

    function automatic logic [PTR_W_MAX-1:0] bin2gray(input logic [PTR_W_MAX-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Narrower pointers are zero-extended by the caller; the leading zeros leave the result unchanged.
    function automatic logic [PTR_W_MAX-1:0] gray2bin(input logic [PTR_W_MAX-1:0] g);
        logic [PTR_W_MAX-1:0] b;
        b[PTR_W_MAX-1] = g[PTR_W_MAX-1];
        for (int i = PTR_W_MAX - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_wr_ctrl_cdc_if.sv
// Producer-side handshake and RAM write port of the FIFO write controller.
interface fifo_wr_ctrl_cdc_if #(
    parameter int ADDR_BITS = 5
);
    logic                 i_valid;
    logic                 o_ready;
    logic                 o_wr_en;
    logic [ADDR_BITS-1:0] o_wr_addr;

    modport master (output i_valid, input o_ready, o_wr_en, o_wr_addr);
    modport slave  (input i_valid, output o_ready, o_wr_en, o_wr_addr);
endinterface

// File: rtl/fifo_wr_ctrl_cdc_ptr_sync.sv
// fifo_ptr_sync: multi-stage async-reset synchroniser for a Gray-coded pointer.
// Shared by the write and read controllers of the dual-clock FIFO.
module fifo_ptr_sync #(
    parameter int WIDTH  = 6,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain [STAGES];

    // NOTE: this array is a handful of flops, not a RAM, so it takes the async reset like any register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                chain[i] <= '0;
            end
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/fifo_wr_ctrl_cdc.sv
// Write-side controller of the dual-clock FIFO: write pointer, Gray export, full/fill status.
// Optional refused-write counter enabled by defining FIFO_WR_DROP_CNT_EN.
module fifo_wr_ctrl_cdc
    import fifo_wr_ctrl_cdc_pkg::*;
#(
    parameter int ADDR_BITS       = 5,
    parameter int ALMOST_FULL_THR = (1 << ADDR_BITS) - 4,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                 wr_clk,
    input  logic                 wr_rst_n,
    fifo_wr_ctrl_cdc_if.slave    wr,
    output logic [ADDR_BITS:0]   o_wr_ptr_gray,
    input  logic [ADDR_BITS:0]   i_rd_ptr_gray,
    output logic [ADDR_BITS:0]   o_fill,
    output logic                 o_almost_full,
    output logic                 o_overflow,
    input  logic                 i_clr_overflow,
    output logic [15:0]          o_drop_cnt
);

    localparam int PW = ADDR_BITS + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(1 << ADDR_BITS);
    localparam logic [PW-1:0] THR_P   = PW'(ALMOST_FULL_THR);

    logic          rst_done_q;
    logic [PW-1:0] wr_bin_q;
    logic [PW-1:0] wr_bin_nxt;
    logic [PW-1:0] rd_gray_s;
    logic [PW-1:0] rd_bin_s;
    logic [PW-1:0] fill;
    logic          full;
    logic          ready;
    logic          accept;
    logic          refuse;

    fifo_ptr_sync #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_rd_sync (
        .clk   (wr_clk),
        .rst_n (wr_rst_n),
        .d     (i_rd_ptr_gray),
        .q     (rd_gray_s)
    );

    // The synced read pointer lags the real one, so fill can only over-estimate occupancy.
    // NOTE: every signal in this block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        rd_bin_s   = PW'(gray2bin(PTR_W_MAX'(rd_gray_s)));
        fill       = wr_bin_q - rd_bin_s;
        full       = (fill == DEPTH_P);
        ready      = rst_done_q & ~full;
        accept     = wr.i_valid & ready;
        refuse     = rst_done_q & wr.i_valid & ~ready;
        wr_bin_nxt = wr_bin_q + PW'(1);
    end

    assign wr.o_ready     = ready;
    assign wr.o_wr_en     = accept;
    assign wr.o_wr_addr   = wr_bin_q[ADDR_BITS-1:0];
    assign o_fill         = rst_done_q ? fill : '0;
    assign o_almost_full  = rst_done_q & (fill >= THR_P);

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            rst_done_q <= 1'b0;
        end else begin
            rst_done_q <= 1'b1;
        end
    end

    // The Gray copy is its own flop so the read domain never samples combinational glitches.
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            wr_bin_q      <= '0;
            o_wr_ptr_gray <= '0;
        end else if (accept) begin
            wr_bin_q      <= wr_bin_nxt;
            o_wr_ptr_gray <= PW'(bin2gray(PTR_W_MAX'(wr_bin_nxt)));
        end
    end

    // A new refusal in the same cycle as a clear keeps the flag up.
    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            o_overflow <= 1'b0;
        end else if (refuse) begin
            o_overflow <= 1'b1;
        end else if (i_clr_overflow) begin
            o_overflow <= 1'b0;
        end
    end

`ifdef FIFO_WR_DROP_CNT_EN
    logic [15:0] drop_q;

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            drop_q <= '0;
        end else if (i_clr_overflow) begin
            drop_q <= '0;
        end else if (refuse && (drop_q != DROP_CNT_MAX)) begin
            drop_q <= drop_q + 16'd1;
        end
    end

    assign o_drop_cnt = drop_q;
`else
    assign o_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl_cdc.sv
// Self-checking bench for fifo_wr_ctrl_cdc at ADDR_BITS=3, ALMOST_FULL_THR=5, SYNC_STAGES=2.
// Reference model tracks unbounded write/read counts and a history of the driven read pointer.
module tb_fifo_wr_ctrl_cdc;

    localparam int AB    = 3;
    localparam int DEPTH = 8;
    localparam int THR   = 5;
    localparam int S     = 2;
    localparam int HMAX  = 8192;

    logic       wr_clk = 1'b0;
    logic       wr_rst_n = 1'b0;
    logic [3:0] wr_ptr_gray;
    logic [3:0] rd_ptr_gray;
    logic [3:0] fill;
    logic       almost_full;
    logic       overflow;
    logic       clr_overflow = 1'b0;
    logic [15:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    // Model state: totals are plain integers that never wrap.
    int rd_total = 0;
    int n        = 0;
    int wr_total = 0;
    int drop_m   = 0;
    bit ovf_m    = 1'b0;
    int hist [0:HMAX-1];

    bit         have_prev = 1'b0;
    logic [3:0] prev_gray = '0;

    fifo_wr_ctrl_cdc_if #(.ADDR_BITS(AB)) wr_bus ();

    fifo_wr_ctrl_cdc #(
        .ADDR_BITS       (AB),
        .ALMOST_FULL_THR (THR),
        .SYNC_STAGES     (S)
    ) dut (
        .wr_clk         (wr_clk),
        .wr_rst_n       (wr_rst_n),
        .wr             (wr_bus.slave),
        .o_wr_ptr_gray  (wr_ptr_gray),
        .i_rd_ptr_gray  (rd_ptr_gray),
        .o_fill         (fill),
        .o_almost_full  (almost_full),
        .o_overflow     (overflow),
        .i_clr_overflow (clr_overflow),
        .o_drop_cnt     (drop_cnt)
    );

    always #5 wr_clk = ~wr_clk;

    function automatic logic [3:0] gray4(input int v);
        int m;
        m = v % 16;
        return 4'(m ^ (m >> 1));
    endfunction

    assign rd_ptr_gray = gray4(rd_total);

    function automatic bit rst_done_m();
        return n >= 1;
    endfunction

    function automatic int rd_seen_m();
        if (n >= S) return hist[n-S+1];
        return 0;
    endfunction

    function automatic int fill_m();
        return rst_done_m() ? (wr_total - rd_seen_m()) : 0;
    endfunction

    function automatic bit ready_m();
        return rst_done_m() && (fill_m() < DEPTH);
    endfunction

    function automatic int drop_exp();
`ifdef FIFO_WR_DROP_CNT_EN
        return drop_m;
`else
        return 0;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one accept per edge while ready; a refusal sets overflow and counts.
    always @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            n        <= 0;
            wr_total <= 0;
            ovf_m    <= 1'b0;
            drop_m   <= 0;
        end else begin
            if (n + 1 < HMAX) begin
                hist[n+1] <= rd_total;
                n         <= n + 1;
            end
            if (wr_bus.i_valid && ready_m()) wr_total <= wr_total + 1;
            if (rst_done_m() && wr_bus.i_valid && !ready_m()) ovf_m <= 1'b1;
            else if (clr_overflow) ovf_m <= 1'b0;
            if (clr_overflow) drop_m <= 0;
            else if (rst_done_m() && wr_bus.i_valid && !ready_m() && drop_m < 65535) drop_m <= drop_m + 1;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge wr_clk) begin
        check("ready",       32'(wr_bus.o_ready),   32'(ready_m()));
        check("wr_en",       32'(wr_bus.o_wr_en),   32'(wr_bus.i_valid && ready_m()));
        check("wr_addr",     32'(wr_bus.o_wr_addr), 32'(wr_total % DEPTH));
        check("wr_ptr_gray", 32'(wr_ptr_gray),      32'(gray4(wr_total)));
        check("fill",        32'(fill),             32'(fill_m()));
        check("almost_full", 32'(almost_full),      32'(rst_done_m() && fill_m() >= THR));
        check("overflow",    32'(overflow),         32'(ovf_m));
        check("drop_cnt",    32'(drop_cnt),         32'(drop_exp()));
        check("fill_le_depth", 32'(fill <= 4'(DEPTH)), 32'd1);
        if (wr_rst_n && have_prev && (wr_ptr_gray != prev_gray))
            check("gray_one_bit", 32'($countones(wr_ptr_gray ^ prev_gray)), 32'd1);
        have_prev <= wr_rst_n;
        prev_gray <= wr_ptr_gray;
    end

    initial begin
        int accepts;
        int k;
        wr_bus.i_valid = 1'b1;
        repeat (3) @(negedge wr_clk);
        #1 wr_rst_n = 1'b1;

        // Reset release with valid held: no accept before the second edge.
        #2;
        check("t1_ready_pre", 32'(wr_bus.o_ready), 32'd0);
        check("t1_wr_en_pre", 32'(wr_bus.o_wr_en), 32'd0);
        accepts = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge wr_clk);
            if (i == 0) check("t1_ready_first", 32'(wr_bus.o_ready), 32'd1);
            if (wr_bus.o_wr_en) accepts++;
        end
        @(negedge wr_clk);
        check("t2_accepts", 32'(accepts), 32'd8);
        check("t2_ready", 32'(wr_bus.o_ready), 32'd0);
        check("t2_fill", 32'(fill), 32'd8);
        check("t2_gray", 32'(wr_ptr_gray), 32'b1100);
        check("t2_no_ovf", 32'(overflow), 32'd0);

        // Three refused cycles while full, then simultaneous refusal and clear.
        repeat (3) @(negedge wr_clk);
        check("t6_ovf", 32'(overflow), 32'd1);
`ifdef FIFO_WR_DROP_CNT_EN
        check("t6_drop", 32'(drop_cnt), 32'd3);
`else
        check("t6_drop", 32'(drop_cnt), 32'd0);
`endif
        #1 clr_overflow = 1'b1;
        @(negedge wr_clk);
        check("t6_set_wins", 32'(overflow), 32'd1);
        check("t6_drop_clr", 32'(drop_cnt), 32'd0);
        #1 wr_bus.i_valid = 1'b0;
        @(negedge wr_clk);
        check("t6_cleared", 32'(overflow), 32'd0);
        #1 clr_overflow = 1'b0;

        // One read frees a slot; visible after exactly S edges.
        rd_total = 1;
        k = 0;
        do begin
            @(negedge wr_clk);
            k++;
        end while (!wr_bus.o_ready && k < 10);
        check("t3_latency", 32'(k), 32'(S));
        check("t3_fill", 32'(fill), 32'd7);

        // Drain to empty; almost_full must track the synced fill.
        while (rd_total < 8) begin
            #1 rd_total = rd_total + 1;
            @(negedge wr_clk);
            if (fill == 4'd5) check("t5_af_at5", 32'(almost_full), 32'd1);
            if (fill == 4'd4) check("t5_af_at4", 32'(almost_full), 32'd0);
        end
        repeat (4) @(negedge wr_clk);
        check("t5_empty_fill", 32'(fill), 32'd0);
        check("t5_empty_af", 32'(almost_full), 32'd0);
        for (int i = 1; i <= 5; i++) begin
            #1 wr_bus.i_valid = 1'b1;
            @(negedge wr_clk);
            check("t5_af_rise", 32'(almost_full), 32'(i >= 5));
        end
        #1 wr_bus.i_valid = 1'b0;

        // Random concurrent traffic: many pointer wraps through 15 -> 0.
        accepts = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge wr_clk);
            if (wr_bus.o_wr_en) accepts++;
            #1;
            wr_bus.i_valid = ($urandom_range(3) != 0);
            if (rd_total < wr_total && $urandom_range(2) != 0) rd_total = rd_total + 1;
        end
        check("t4_enough_writes", 32'(accepts >= 40), 32'd1);
        @(negedge wr_clk);
        #1 wr_bus.i_valid = 1'b0;
        for (int c = 0; c < 40 && rd_total < wr_total; c++) begin
            @(negedge wr_clk);
            #1 rd_total = rd_total + 1;
        end
        repeat (4) @(negedge wr_clk);
        check("t4_drained", 32'(fill), 32'd0);

        // Reset mid-burst clears everything at once; the read side resets too.
        #1 wr_bus.i_valid = 1'b1;
        repeat (3) @(negedge wr_clk);
        #1;
        wr_rst_n = 1'b0;
        rd_total = 0;
        @(negedge wr_clk);
        check("t7_ready", 32'(wr_bus.o_ready), 32'd0);
        check("t7_gray", 32'(wr_ptr_gray), 32'd0);
        check("t7_fill", 32'(fill), 32'd0);
        check("t7_addr", 32'(wr_bus.o_wr_addr), 32'd0);
        #1 wr_rst_n = 1'b1;
        repeat (4) @(negedge wr_clk);
        check("t7_after_fill", 32'(fill), 32'd3);

        #1 wr_bus.i_valid = 1'b0;
        @(negedge wr_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
